drv_sleep_sequencer: RTL and testbench
======================================

# drv_sleep_sequencer

Parametrised power-sequencing block for the motor-driver sleep lines. It sits between the PFS core's per-column enable vector and the board's active-low driver sleep pins, and generalises the fixed four-group direct mapping to `GROUPS` channels. Drivers are woken one group at a time with a guaranteed stagger, which limits supply inrush on the 10 V rail. Disables, individual or forced, take effect on the next clock with no stagger.

## Interface
- `GROUPS`, default 4: number of driver groups (1–16).
- `IN_FREQ_KHZ`, default 16000: `clkin` frequency.
- `STAGGER_US`, default 50: minimum spacing between two group wake-ups.
- `HOLD_OFF_US`, default 10: minimum sleep time before a group may re-wake (only with the macro in Configuration).
- Derived constants:
  - `STAGGER_CYC = IN_FREQ_KHZ*STAGGER_US/1000`, which must be ≥ 1.
  - `HOLDOFF_CYC = IN_FREQ_KHZ*HOLD_OFF_US/1000`.
  - Counter widths are `$clog2(STAGGER_CYC+1)` and `$clog2(HOLDOFF_CYC+1)`.

Ports:
- `clkin`, in, 1: single clock (16 MHz command clock domain).
- `rst_n`, in, 1: asynchronous, active-low reset.
- `en_req`, in, GROUPS: requested group enables, synchronous to `clkin`, level-sensitive.
- `force_off`, in, 1: fault or shutdown request; active high, level-sensitive.
- `sleep_n`, out, GROUPS: driver sleep pins; 1 = awake.
- `seq_busy`, out, 1: high while a stagger interval is running.
- `in_sync`, out, 1: high when `sleep_n` equals `en_req` and no stagger is running.

## Operation
- State machine `IDLE`, `SETTLE`. Counter `stg_cnt`.
- `eligible[i] = en_req[i] & ~sleep_n[i] & ~force_off & holdoff_clear[i]`.
- **IDLE:**
  - If any `eligible` bit is set, the next edge sets `sleep_n[i]` for the lowest eligible index `i` only.
  - On the same edge, load `stg_cnt = STAGGER_CYC-1` and move to `SETTLE`.
- **SETTLE:**
  - If `stg_cnt != 0`, decrement it.
  - If `stg_cnt == 0` and any bit is eligible, wake the lowest eligible group, reload `stg_cnt`, and stay in `SETTLE`.
  - If `stg_cnt == 0` and nothing is eligible, go to `IDLE`.
- **Disable:** if `en_req[i]` is 0 while `sleep_n[i]` is 1, the next edge clears `sleep_n[i]`. This applies in any state and does not disturb `stg_cnt`. The stagger keeps running even if the group just woken is dropped.
- **force_off:**
  - The next edge clears all `sleep_n` bits, forces the state to `IDLE`, and sets `stg_cnt` to 0.
  - No wakes occur while `force_off` is high.
  - On release, sequencing restarts from the lowest-index request.
- **Simultaneous events:**
  - Disable of group j and wake of group i on the same edge: both take effect.
  - A group already awake is never re-woken and never consumes a stagger slot.
- **Registered outputs:**
  - `seq_busy = (state == SETTLE)`.
  - `in_sync = (next sleep_n == en_req) & (next state == IDLE)`.
- **Reset (asynchronous, active-low):**
  - `sleep_n = 0`, `seq_busy = 0`, `in_sync = 0`, state `IDLE`, all counters 0.
  - Reset asserted mid-sequence immediately sleeps all groups.

## Timing
- Wake latency: a request that becomes eligible at edge k, with the block in `IDLE`, gives a `sleep_n` rise at edge k+1.
- Wake spacing: consecutive wake edges are exactly `STAGGER_CYC` cycles apart while requests are pending, and never fewer.
- Disable latency: 1 cycle from `en_req` fall or `force_off` rise.
- `seq_busy` is high for exactly `STAGGER_CYC` cycles after the final wake.
- `in_sync` is valid 1 cycle after reset release.
- No combinational path from any input to any output.

## Configuration
- `DRV_SLEEP_HOLDOFF_EN` defined:
  - Each group has a hold-off counter, loaded with `HOLDOFF_CYC` on every 1→0 transition of `sleep_n[i]`. The cause does not matter: disable, `force_off`, or none (reset clears it to 0).
  - The counter decrements to 0. `holdoff_clear[i] = (cnt_i == 0)`.
  - A group cannot wake until `HOLDOFF_CYC` cycles have passed since it slept.
- Not defined: `holdoff_clear` is tied to 1, no hold-off counters are built, and `HOLD_OFF_US` is ignored.

## Test plan
Defaults unless stated (`STAGGER_CYC` = 800, `HOLDOFF_CYC` = 160).
- **Staggered wake:** `en_req` 0000→1111 at edge 10 -> `sleep_n` bits 0, 1, 2, 3 rise at edges 11, 811, 1611, 2411; `seq_busy` falls at 3211; then `in_sync` = 1.
- **Immediate disable mid-sequence:** `en_req` = 1111, then `en_req[0]` dropped at edge 400 -> `sleep_n[0]` = 0 at 401; group 1 still wakes at 811.
- **Force off:** `force_off` pulsed at edge 1000 for 5 cycles during wake-up -> all `sleep_n` = 0 at 1001; after release, group 0 wakes 1 cycle after `force_off` falls.
- **Hold-off (macro defined):** group 2 disabled at edge 5000, re-requested at 5010 -> wake at 5161, not earlier. With the macro undefined: wake at 5011.
- **Reset mid-operation:** `rst_n` low at edge 900 with 2 groups awake -> `sleep_n` = 0 asynchronously; after release with `en_req` = 1111, sequencing restarts at group 0.
- **Parametrisation:** `GROUPS` = 16, `STAGGER_US` = 1 (16 cycles), all requested -> 16 wakes spaced 16 cycles, lowest index first.

Source files
------------

// File: rtl/drv_sleep_sequencer.sv
// drv_sleep_sequencer
//
// Power-sequencing block for the motor-driver sleep lines. It wakes requested
// driver groups one at a time, keeping a minimum spacing between wake-ups so
// the 10 V rail sees limited inrush. Disables, whether per group or forced,
// take effect on the next clock with no stagger.
//
// Optional feature macro: DRV_SLEEP_HOLDOFF_EN
//   defined   : every group gets a hold-off counter, so a group that has just
//               gone to sleep cannot re-wake until HOLDOFF_CYC cycles pass.
//   undefined : no hold-off counters are built and HOLD_OFF_US has no effect.
//
// Parameters:
//   GROUPS      number of driver groups (1..16)
//   IN_FREQ_KHZ clkin frequency in kHz
//   STAGGER_US  minimum spacing between two group wake-ups (must give >= 1 cycle)
//   HOLD_OFF_US minimum sleep time before a re-wake (hold-off builds only)
//
// Ports:
//   clkin      in   1       command clock
//   rst_n      in   1       asynchronous active-low reset
//   en_req     in   GROUPS  requested group enables, level-sensitive
//   force_off  in   1       fault/shutdown request, active high
//   sleep_n    out  GROUPS  driver sleep pins, 1 = awake
//   seq_busy   out  1       high while a stagger interval is running
//   in_sync    out  1       sleep_n matches en_req and no stagger running
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | no stagger running; the next eligible request wakes at once
// SETTLE | stagger interval running; stg_cnt counts down to the next slot

module drv_sleep_sequencer #(
  parameter int GROUPS      = 4,
  parameter int IN_FREQ_KHZ = 16000,
  parameter int STAGGER_US  = 50,
  parameter int HOLD_OFF_US = 10
) (
  input  logic              clkin,
  input  logic              rst_n,
  input  logic [GROUPS-1:0] en_req,
  input  logic              force_off,
  output logic [GROUPS-1:0] sleep_n,
  output logic              seq_busy,
  output logic              in_sync
);

  localparam int STAGGER_CYC = IN_FREQ_KHZ * STAGGER_US / 1000;
  localparam int STG_W       = $clog2(STAGGER_CYC + 1);
  localparam logic [STG_W-1:0] STG_RELOAD = STG_W'(STAGGER_CYC - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    SETTLE = 1'b1
  } state_t;

  state_t            state, state_nxt;
  logic [STG_W-1:0]  stg_cnt, stg_cnt_nxt;
  logic [GROUPS-1:0] holdoff_clear;
  logic [GROUPS-1:0] eligible;
  logic [GROUPS-1:0] wake_sel;
  logic [GROUPS-1:0] sleep_nxt;
  logic              slot_open;

  always_comb begin
    eligible    = en_req & ~sleep_n & holdoff_clear & {GROUPS{~force_off}};
    // Isolate the lowest set bit: only one group may wake per slot.
    wake_sel    = eligible & (~eligible + GROUPS'(1));
    slot_open   = (state == IDLE) || (stg_cnt == '0);
    // Disables apply in every state and never touch the stagger counter.
    sleep_nxt   = sleep_n & en_req;
    state_nxt   = state;
    stg_cnt_nxt = stg_cnt;
    if (force_off) begin
      sleep_nxt   = '0;
      state_nxt   = IDLE;
      stg_cnt_nxt = '0;
    end else if (slot_open && (|eligible)) begin
      sleep_nxt   = sleep_nxt | wake_sel;
      state_nxt   = SETTLE;
      stg_cnt_nxt = STG_RELOAD;
    end else if (state == SETTLE) begin
      if (stg_cnt != '0) begin
        stg_cnt_nxt = stg_cnt - STG_W'(1);
      end else begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      stg_cnt  <= '0;
      sleep_n  <= '0;
      seq_busy <= 1'b0;
      in_sync  <= 1'b0;
    end else begin
      state    <= state_nxt;
      stg_cnt  <= stg_cnt_nxt;
      sleep_n  <= sleep_nxt;
      // Both flags are taken from next-state values so they line up with
      // the registered state and sleep_n they describe.
      seq_busy <= (state_nxt == SETTLE);
      in_sync  <= (sleep_nxt == en_req) && (state_nxt == IDLE);
    end
  end

`ifdef DRV_SLEEP_HOLDOFF_EN
  localparam int HOLDOFF_CYC = IN_FREQ_KHZ * HOLD_OFF_US / 1000;
  localparam int HO_W        = (HOLDOFF_CYC > 0) ? $clog2(HOLDOFF_CYC + 1) : 1;

  logic [HO_W-1:0] ho_cnt [GROUPS];

  // Reload on every awake->asleep transition, whatever caused it.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < GROUPS; i++) ho_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < GROUPS; i++) begin
        if (sleep_n[i] && !sleep_nxt[i]) begin
          ho_cnt[i] <= HO_W'(HOLDOFF_CYC);
        end else if (ho_cnt[i] != '0) begin
          ho_cnt[i] <= ho_cnt[i] - HO_W'(1);
        end
      end
    end
  end

  always_comb begin
    holdoff_clear = '0;
    for (int i = 0; i < GROUPS; i++) holdoff_clear[i] = (ho_cnt[i] == '0);
  end
`else
  // Without hold-off every group is always clear; HOLD_OFF_US folds to a
  // constant that cannot change the result.
  assign holdoff_clear = {GROUPS{1'b1}} | {GROUPS{HOLD_OFF_US < 0}};
`endif

endmodule

// File: tb/tb_drv_sleep_sequencer.sv
module tb_drv_sleep_sequencer;

  localparam int GROUPS      = 4;
  localparam int IN_FREQ_KHZ = 16000;
  localparam int STAGGER_US  = 50;
  localparam int HOLD_OFF_US = 10;
  localparam int S = IN_FREQ_KHZ * STAGGER_US / 1000;
`ifdef DRV_SLEEP_HOLDOFF_EN
  localparam int H = IN_FREQ_KHZ * HOLD_OFF_US / 1000;
`else
  localparam int H = 0;
`endif
  localparam longint NEG = -1000000;

  logic              clkin = 1'b0;
  logic              rst_n = 1'b1;
  logic [GROUPS-1:0] en_req = '0;
  logic              force_off = 1'b0;
  logic [GROUPS-1:0] sleep_n;
  logic              seq_busy;
  logic              in_sync;

  drv_sleep_sequencer #(
    .GROUPS(GROUPS), .IN_FREQ_KHZ(IN_FREQ_KHZ),
    .STAGGER_US(STAGGER_US), .HOLD_OFF_US(HOLD_OFF_US)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .en_req(en_req), .force_off(force_off),
    .sleep_n(sleep_n), .seq_busy(seq_busy), .in_sync(in_sync)
  );

  always #5 clkin = ~clkin;

  typedef struct packed {
    logic [GROUPS-1:0] sn;
    logic              busy;
    logic              sync;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: time-stamp based. A wake slot is open once S edges have
  // passed since the last wake; a group is held off until more than H edges
  // have passed since it last went to sleep.
  longint            t = 0;
  longint            last_wake;
  longint            last_sleep [GROUPS];
  logic [GROUPS-1:0] m_sn;

  task automatic model_reset();
    m_sn      = '0;
    last_wake = NEG;
    for (int i = 0; i < GROUPS; i++) last_sleep[i] = NEG;
  endtask

  // Predict the DUT outputs after the coming rising edge, given the inputs
  // currently applied.
  task automatic predict();
    logic [GROUPS-1:0] nxt;
    logic              woke;
    exp_t              e;
    t++;
    nxt  = m_sn;
    woke = 1'b0;
    if (force_off) begin
      for (int i = 0; i < GROUPS; i++) if (m_sn[i]) last_sleep[i] = t;
      nxt       = '0;
      last_wake = NEG;
    end else begin
      for (int i = 0; i < GROUPS; i++)
        if (m_sn[i] && !en_req[i]) begin
          nxt[i]        = 1'b0;
          last_sleep[i] = t;
        end
      if (t - last_wake >= S)
        for (int i = 0; i < GROUPS; i++)
          if (!woke && en_req[i] && !m_sn[i] && (t - last_sleep[i] > H)) begin
            nxt[i]    = 1'b1;
            last_wake = t;
            woke      = 1'b1;
          end
    end
    m_sn   = nxt;
    e.sn   = nxt;
    e.busy = (t - last_wake) < S;
    e.sync = (nxt == en_req) && !e.busy;
    exp_q.push_back(e);
  endtask

  task automatic step(input logic [GROUPS-1:0] en, input logic fo, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clkin);
      en_req    = en;
      force_off = fo;
      predict();
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests++;
    if (sleep_n !== '0 || seq_busy !== 1'b0 || in_sync !== 1'b0) begin
      fails++;
      $display("FAIL %s: got sleep_n=%b busy=%b sync=%b, want all zero",
               name, sleep_n, seq_busy, in_sync);
    end
  endtask

  // Reset asserted between edges; outputs must clear without a clock.
  task automatic do_reset(input string name);
    @(negedge clkin);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs(name);
    repeat (3) @(negedge clkin);
    rst_n = 1'b1;
    model_reset();
    predict();
  endtask

  // Monitor: every edge the DUT presents a new output word.
  always @(posedge clkin) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tests++;
      if ({sleep_n, seq_busy, in_sync} !== e) begin
        fails++;
        $display("FAIL cycle %0d: got sleep_n=%b busy=%b sync=%b, want sleep_n=%b busy=%b sync=%b",
                 t, sleep_n, seq_busy, in_sync, e.sn, e.busy, e.sync);
      end
    end
  end

  initial begin
    logic [GROUPS-1:0] en;
    logic              fo;
    int                len;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("reset_state");
    repeat (3) @(negedge clkin);
    rst_n = 1'b1;
    predict();

    // Staggered wake of all groups, then settle into sync.
    step('0, 1'b0, 9);
    step('1, 1'b0, 3300);
    // Disable all at once, then a disable in the middle of a stagger.
    step('0, 1'b0, 10);
    step('1, 1'b0, 400);
    step(4'b1110, 1'b0, 500);
    // force_off pulse during wake-up and restart afterwards.
    step('1, 1'b0, 100);
    step('1, 1'b1, 5);
    step('1, 1'b0, 2000);
    // Drop and re-request group 2 (hold-off window when enabled).
    step(4'b1011, 1'b0, 10);
    step('1, 1'b0, 300);
    // Reset with two groups awake, then sequencing restarts from group 0.
    step('0, 1'b0, 10);
    step('1, 1'b0, 900);
    do_reset("reset_async_mid");
    step('1, 1'b0, 3300);

    // Randomised segments: mixture of long holds and short glitches.
    for (int seg = 0; seg < 60; seg++) begin
      en  = GROUPS'($urandom);
      fo  = ($urandom_range(0, 7) == 0);
      len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 5) : $urandom_range(1, 1200);
      step(en, fo, len);
      if ($urandom_range(0, 29) == 0) do_reset("reset_async_rand");
    end

    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge clkin);
    #2;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: %0d expected outputs never checked, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
